ternary_neuron_acc: RTL

Sequential ternary-neuron accumulator sitting directly downstream of the 6-input (approximate) popcount stage. Each cycle it accepts one pair of 3-bit popcounts, one for inputs under +1 weights and one for inputs under −1 weights, and accumulates their signed difference over `N_CHUNKS` chunks. It then compares the sum against two thresholds and emits one ternary activation per neuron evaluation through a valid/ready handshake.

---
 rtl/tnn_pkg.sv | 27 ++
 rtl/ternary_thresh.sv | 21 ++
 rtl/ternary_neuron_acc.sv | 114 +++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// Shared types and constants for the ternary-neuron datapath: trit encoding,
// accumulator FSM states and the popcount width used by the popcount stages.
package tnn_pkg;

  localparam int PC_W   = 3;
  localparam int DIFF_W = PC_W + 1;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b11;
  localparam trit_t TRIT_ZERO = 2'b00;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Signed difference of two unsigned popcounts, range -7..+7.
  function automatic logic signed [DIFF_W-1:0] pc_diff(
    input logic [PC_W-1:0] pos,
    input logic [PC_W-1:0] neg
  );
    return $signed({1'b0, pos}) - $signed({1'b0, neg});
  endfunction

endpackage

// File: rtl/ternary_thresh.sv
// Combinational ternary activation: +1 if sum >= hi, else -1 if sum <= lo,
// else 0. The +1 test wins when the two thresholds overlap.
module ternary_thresh
  import tnn_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic signed [ACC_W-1:0] i_sum,
  input  logic signed [ACC_W-1:0] i_thr_hi,
  input  logic signed [ACC_W-1:0] i_thr_lo,
  output trit_t                   o_trit
);

  // NOTE: o_trit gets a default before the if-chain so no latch is inferred.
  always_comb begin
    o_trit = TRIT_ZERO;
    if (i_sum >= i_thr_hi)      o_trit = TRIT_POS;
    else if (i_sum <= i_thr_lo) o_trit = TRIT_NEG;
  end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Sequential ternary-neuron accumulator: sums (pc_pos - pc_neg) over N_CHUNKS
// transfers, then holds one registered trit/sum result until consumed.
// Build option TNN_ACC_SAT_EN: saturating accumulator instead of wrap-around.
module ternary_neuron_acc
  import tnn_pkg::*;
#(
  parameter int N_CHUNKS = 8,
  parameter int ACC_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PC_W-1:0]         pc_pos,
  input  logic [PC_W-1:0]         pc_neg,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_trit,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  trit_t                   r_out_trit;
  logic signed [ACC_W-1:0] r_out_sum;

  logic signed [DIFF_W-1:0] w_diff;
  logic signed [ACC_W-1:0]  w_acc_next;
  trit_t                    w_trit;

  assign w_diff = pc_diff(pc_pos, pc_neg);

`ifdef TNN_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit is enough: |diff| <= 7 is far below 2^(ACC_W-1) for ACC_W >= 4.
  logic signed [ACC_W:0] w_sum_wide;
  assign w_sum_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_diff);

  always_comb begin
    w_acc_next = w_sum_wide[ACC_W-1:0];
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1])
      w_acc_next = w_sum_wide[ACC_W] ? SUM_MIN : SUM_MAX;
  end
`else
  assign w_acc_next = r_acc + ACC_W'(w_diff);
`endif

  // The compare sees the sum including the current chunk, so the result is
  // ready to register on the final transfer.
  ternary_thresh #(.ACC_W(ACC_W)) u_thresh (
    .i_sum    (w_acc_next),
    .i_thr_hi (thr_hi),
    .i_thr_lo (thr_lo),
    .o_trit   (w_trit)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_trit  <= TRIT_ZERO;
      r_out_sum   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            if (r_cnt == LAST_CNT) begin
              r_out_sum   <= w_acc_next;
              r_out_trit  <= w_trit;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_trit  = r_out_trit;
  assign out_sum   = r_out_sum;

endmodule
